// File: rtl/spi_master_cfg.sv
// Configurable SPI master: DW-bit words, SCLK = mclk/(2*DIV), all CPOL/CPHA modes,
// MSB/LSB-first ordering and one-hot active-low chip selects.
module spi_master_cfg #(
  parameter int DW  = 8,
  parameter int DIV = 2,
  parameter int NCS = 4,
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic           mclk,
  input  logic           reset,
  input  logic           start,
  input  logic           cpol,
  input  logic           cpha,
  input  logic           lsb_first,
  input  logic [CSW-1:0] cs_sel,
  input  logic [DW-1:0]  data_in,
  input  logic           miso,
  output logic           sclk,
  output logic           mosi,
  output logic [NCS-1:0] cs_n,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  data_out
);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EW = $clog2(2 * DW);
  localparam logic [TW-1:0] TMAX  = TW'(DIV - 1);
  localparam logic [EW-1:0] ELAST = EW'(2 * DW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [EW-1:0]  ecnt_q, ecnt_d;
  logic           cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DW-1:0]  tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic           sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NCS-1:0] cs_n_q, cs_n_d;
  logic           active, tick, sample;
  logic [DW-1:0]  ord;

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  assign active = (state_q == S_SETUP) || (state_q == S_XFER) || (state_q == S_HOLD);
  assign tick   = active && (tmr_q == TMAX);
  // Even edge index = leading edge; sample on leading when cpha=0, trailing when cpha=1.
  assign sample = ~ecnt_q[0] ^ cpha_q;
  assign ord    = lsb_first ? rev(data_in) : data_in;

  always_comb begin
    state_d = state_q;
    tmr_d   = active ? (tick ? '0 : tmr_q + 1'b1) : '0;
    ecnt_d  = ecnt_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        if (start) begin
          state_d = S_SETUP;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          // cpha=0 puts the first bit out now, so the register starts one bit ahead.
          tx_d    = cpha ? ord : (ord << 1);
          mosi_d  = ord[DW-1];
          rx_d    = '0;
          ecnt_d  = '0;
          busy_d  = 1'b1;
          for (int i = 0; i < NCS; i++) cs_n_d[i] = (32'(cs_sel) != i);
        end
      end
      S_SETUP: if (tick) state_d = S_XFER;
      S_XFER: if (tick) begin
        sclk_d = ~sclk_q;
        ecnt_d = ecnt_q + 1'b1;
        if (sample) begin
          rx_d = {rx_q[DW-2:0], miso};
        end else if (ecnt_q != ELAST) begin
          mosi_d = tx_q[DW-1];
          tx_d   = tx_q << 1;
        end
        if (ecnt_q == ELAST) state_d = S_HOLD;
      end
      S_HOLD: if (tick) begin
        state_d = S_DONE;
        cs_n_d  = '1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dout_d  = lsb_q ? rev(rx_q) : rx_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ecnt_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= '1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ecnt_q  <= ecnt_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboarded bench for spi_master_cfg: an 8-bit/DIV=2 instance and a 16-bit/DIV=1 instance.
module tb_spi_master_cfg;
  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  logic        start0, start1, cpol, cpha, lsb;
  logic [1:0]  cs_sel0, cs_sel1;
  logic [7:0]  din0, dout0;
  logic [15:0] din1, dout1;
  logic        miso0, miso1, sclk0, sclk1, mosi0, mosi1;
  logic        busy0, busy1, done0, done1;
  logic [3:0]  cs_n0, cs_n1;

  logic       use_slave, miso_s;
  logic [7:0] sl_tx, cap0;
  int         rise0, cyc, vecs, miss;

  typedef struct {logic [15:0] data; int lat; int issue;} exp_t;
  exp_t q0[$], q1[$];

  assign miso0 = use_slave ? miso_s : mosi0;
  assign miso1 = mosi1;

  spi_master_cfg #(.DW(8), .DIV(2), .NCS(4)) u0 (
    .mclk(mclk), .reset(reset), .start(start0), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb), .cs_sel(cs_sel0), .data_in(din0), .miso(miso0),
    .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0), .busy(busy0), .done(done0), .data_out(dout0));

  spi_master_cfg #(.DW(16), .DIV(1), .NCS(4)) u1 (
    .mclk(mclk), .reset(reset), .start(start1), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb), .cs_sel(cs_sel1), .data_in(din1), .miso(miso1),
    .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .done(done1), .data_out(dout1));

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave-side observers: rising-edge count, MOSI bits on the sample edge, mode-3 slave drive.
  always @(posedge sclk0) if (cs_n0 != 4'hf) rise0++;
  always @(sclk0) if (cs_n0 != 4'hf && sclk0 == ~(cpol ^ cpha)) cap0 = {cap0[6:0], mosi0};
  always @(negedge sclk0) if (use_slave && cs_n0 != 4'hf) begin
    miso_s = sl_tx[7];
    sl_tx  = sl_tx << 1;
  end

  // Monitors: every done pulse pops one expectation.
  always @(negedge mclk) if (reset && done0) begin
    if (q0.size() == 0) begin
      vecs++; miss++;
      $display("FAIL u0_unexpected_done: got done=1 expected none (data_out=0x%0h)", dout0);
    end else begin
      exp_t e;
      e = q0.pop_front();
      chk("u0_data_out", 32'(dout0), 32'(e.data));
      chk("u0_latency", cyc - e.issue, e.lat);
    end
  end
  always @(negedge mclk) if (reset && done1) begin
    if (q1.size() == 0) begin
      vecs++; miss++;
      $display("FAIL u1_unexpected_done: got done=1 expected none (data_out=0x%0h)", dout1);
    end else begin
      exp_t e;
      e = q1.pop_front();
      chk("u1_data_out", 32'(dout1), 32'(e.data));
      chk("u1_latency", cyc - e.issue, e.lat);
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic issue0(input logic [7:0] d, input logic [1:0] cs, input logic [7:0] exp, input bit push);
    cyc_wait(1);
    start0 = 1'b1; din0 = d; cs_sel0 = cs;
    if (push) q0.push_back('{data: 16'(exp), lat: 37, issue: cyc});
    cyc_wait(1);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    for (int n = 0; n < 200; n++) begin
      if (done0) return;
      cyc_wait(1);
    end
    vecs++; miss++;
    $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = 0; miss = 0; cyc = 0; rise0 = 0; cap0 = '0;
    start0 = 0; start1 = 0; cpol = 0; cpha = 0; lsb = 0;
    cs_sel0 = 0; cs_sel1 = 0; din0 = 0; din1 = 0;
    use_slave = 0; miso_s = 0; sl_tx = 0;
    reset = 0;
    #23;
    chk("rst_cs_n", 32'(cs_n0), 32'hf);
    chk("rst_sclk", 32'(sclk0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_data_out", 32'(dout0), 0);
    reset = 1;
    cyc_wait(3);

    // 1: mode 0 loopback 0x46 on slave 0
    rise0 = 0; cap0 = 0;
    issue0(8'h46, 2'd0, 8'h46, 1);
    chk("t1_busy", 32'(busy0), 1);
    cyc_wait(8);
    chk("t1_cs_n", 32'(cs_n0), 32'he);
    wait_done0("t1");
    chk("t1_sclk_rises", rise0, 8);
    chk("t1_mosi_seq", 32'(cap0), 32'h46);
    chk("t1_cs_n_done", 32'(cs_n0), 32'hf);
    cyc_wait(3);

    // 2: mode 3 against a slave returning 0xA5
    cpol = 1; cpha = 1; use_slave = 1; sl_tx = 8'hA5; cap0 = 0;
    cyc_wait(3);
    chk("t2_idle_high_before", 32'(sclk0), 1);
    issue0(8'h3C, 2'd1, 8'hA5, 1);
    wait_done0("t2");
    chk("t2_slave_saw", 32'(cap0), 32'h3C);
    cyc_wait(2);
    chk("t2_idle_high_after", 32'(sclk0), 1);
    use_slave = 0;

    // 3: mode 1, LSB first, loopback 0x01
    cpol = 0; cpha = 1; lsb = 1; cap0 = 0;
    cyc_wait(3);
    issue0(8'h01, 2'd3, 8'h01, 1);
    wait_done0("t3");
    chk("t3_mosi_seq", 32'(cap0), 32'h80);
    cpha = 0; lsb = 0;
    cyc_wait(3);

    // 4: restarts and input changes mid-transfer are ignored; back-to-back start after done
    issue0(8'h9C, 2'd0, 8'h9C, 1);
    cyc_wait(3);
    start0 = 1; din0 = 8'h11; cpol = 1; cs_sel0 = 2'd3;
    cyc_wait(1);
    start0 = 0;
    cyc_wait(14);
    start0 = 1; lsb = 1;
    cyc_wait(1);
    start0 = 0; cpol = 0; lsb = 0;
    chk("t4_cs_n_mid", 32'(cs_n0), 32'he);
    wait_done0("t4a");
    chk("t4_cs_n_gap_done", 32'(cs_n0), 32'hf);
    cyc_wait(1);
    chk("t4_cs_n_gap_idle", 32'(cs_n0), 32'hf);
    start0 = 1; din0 = 8'hE7; cs_sel0 = 2'd1;
    q0.push_back('{data: 16'hE7, lat: 37, issue: cyc});
    cyc_wait(1);
    start0 = 0;
    chk("t4_second_busy", 32'(busy0), 1);
    chk("t4_second_cs_n", 32'(cs_n0), 32'hd);
    wait_done0("t4b");
    cyc_wait(3);

    // 5: reset mid-transfer aborts immediately with no done
    issue0(8'hC3, 2'd2, 8'h00, 0);
    cyc_wait(14);
    reset = 0;
    #1;
    chk("t5_cs_n", 32'(cs_n0), 32'hf);
    chk("t5_sclk", 32'(sclk0), 0);
    chk("t5_busy", 32'(busy0), 0);
    chk("t5_data_out", 32'(dout0), 0);
    cyc_wait(3);
    reset = 1;
    cyc_wait(50);
    chk("t5_no_done_data_out", 32'(dout0), 0);
    issue0(8'h5A, 2'd1, 8'h5A, 1);
    wait_done0("t5");
    cyc_wait(3);

    // 6: 16-bit, DIV=1, slave 2, loopback 0xBEEF
    cyc_wait(1);
    start1 = 1; din1 = 16'hBEEF; cs_sel1 = 2'd2;
    q1.push_back('{data: 16'hBEEF, lat: 35, issue: cyc});
    cyc_wait(1);
    start1 = 0;
    cyc_wait(5);
    chk("t6_cs_n", 32'(cs_n1), 32'hb);
    for (int n = 0; n < 100 && !done1; n++) cyc_wait(1);
    cyc_wait(5);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
